cpu_run_controller: RTL
=======================

// Module: cpu_run_controller
// PURPOSE
//  Sequences the single-cycle core ("singlecycle") through one program run: holds the core in reset with a start PC, syncs to it,
//  runs until currentpc reaches a stop PC, captures the last MemtoRegOut seen before the stop PC, and reports the result.
//  Sits between a host/bench and the core; replaces hand-written reset/wait/run loops with one reusable sequencer.
// PARAMETERS
//  PC_W          64  width of PC and data paths
//  CYC_W         16  width of run-cycle counter and max_cycles
//  RESET_CYCLES  1   cycles core reset is held high per run (>=1)
//  SYNC_LIMIT    8   max cycles in SYNC waiting for currentpc==start_pc
// PORTS
//  CLK           in   1      clock, all logic on posedge
//  reset         in   1      synchronous, active-low reset
//  start         in   1      run request; sampled only in IDLE or DONE
//  start_pc      in   PC_W   program entry PC, latched on accepted start
//  stop_pc       in   PC_W   run ends when currentpc >= stop_pc (unsigned), latched on start
//  max_cycles    in   CYC_W  RUN-cycle budget (used only with WATCHDOG_EN), latched on start
//  cpu_reset     out  1      to core reset (active-high, as the core expects)
//  cpu_startpc   out  PC_W   to core startpc
//  cpu_currentpc in   PC_W   from core currentpc
//  cpu_m2r       in   PC_W   from core MemtoRegOut
//  busy          out  1      high in RESET, SYNC, RUN
//  done          out  1      high while in DONE (sticky until next accepted start)
//  result        out  PC_W   last cpu_m2r sampled in RUN before stop
//  cycles        out  CYC_W  RUN cycles executed (saturates at all-ones)
//  sync_err      out  1      SYNC_LIMIT expired without PC match
//  timeout       out  1      watchdog expiry (WATCHDOG_EN only)
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE; cpu_reset=1; cpu_startpc=0; busy=done=sync_err=timeout=0; result=0; cycles=0.
//  Applies mid-run too: core is re-parked in reset, no partial result is flagged done.
//  States: IDLE, RESET, SYNC, RUN, DONE. cpu_reset=1 in IDLE and RESET, 0 in SYNC/RUN/DONE.
//  IDLE/DONE + start: latch start_pc/stop_pc/max_cycles; cpu_startpc<=start_pc; clear result, cycles, done, sync_err,
//   timeout; -> RESET. start while busy is ignored.
//  RESET: hold RESET_CYCLES cycles (counter), then -> SYNC.
//  SYNC: each cycle compare cpu_currentpc==start_pc; match -> RUN next cycle. After SYNC_LIMIT non-matching cycles:
//   sync_err<=1, -> DONE.
//  RUN, per cycle: if cpu_currentpc >= stop_pc -> DONE (no capture this cycle); else result<=cpu_m2r,
//   cycles<=cycles+1 (saturating). Thus result = MemtoRegOut of the instruction at the last PC < stop_pc.
//  stop_pc <= start_pc: first RUN cycle exits; result=0, cycles=0, done=1.
//  DONE: done=1, busy=0, outputs frozen; cpu_reset stays 0 (core free-runs, ignored).
//  Latency: start accepted at edge N -> cpu_reset high edges N+1..N+RESET_CYCLES; earliest RUN at N+RESET_CYCLES+2.
//  All compares unsigned, full PC_W. No combinational path from inputs to outputs.
// CONFIGURATION
//  WATCHDOG_EN defined: in RUN, if cycles==max_cycles (pre-increment) and PC < stop_pc -> timeout<=1, -> DONE, no capture.
//   max_cycles==0 disables the check for that run.
//  WATCHDOG_EN undefined: no watchdog logic; timeout tied 0; max_cycles ignored; run ends only on stop_pc or sync_err.
// TESTING (stub core: PC=cpu_startpc while cpu_reset, else PC+=4 per cycle; m2r=PC)
//  1. start_pc=0x0, stop_pc=0x34, start pulse -> done=1, result=0x30, cycles=13, sync_err=0, timeout=0.
//  2. Then start_pc=0x34, stop_pc=0x58 -> result=0x54, cycles=9; cpu_reset high exactly RESET_CYCLES cycles.
//  3. stop_pc=0x10, start_pc=0x20 -> done within RESET_CYCLES+3 cycles, result=0, cycles=0.
//  4. Stub core pinned at PC=0xFFFF -> sync_err=1, done=1 after SYNC_LIMIT SYNC cycles; result=0.
//  5. WATCHDOG_EN, start 0x0, stop 0x1000, max_cycles=5 -> timeout=1, cycles=5, result=0x10; without macro: runs to 0x1000,
//     timeout=0.
//  6. reset low during RUN -> next edge all outputs at reset values, cpu_reset=1; start while busy ignored (latched PCs unchanged).
//  Real core: program at 0x0 stop 0x34 -> result 0xF; program at 0x34 stop 0x58 -> result 0x123456789ABCDEF0.

Source files
------------

// File: rtl/cpu_run_controller.sv
// cpu_run_controller
// Sequences the single-cycle core through one program run. The core is parked
// in reset with a start PC, the controller waits for the core to report that
// PC, then lets the core run until currentpc reaches the stop PC. The last
// MemtoRegOut seen below the stop PC is kept as the run result.
//
// Optional feature macro: WATCHDOG_EN
//   defined   - a run also ends when the RUN-cycle count reaches max_cycles
//               (max_cycles == 0 disables the check for that run); timeout is set
//   undefined - no watchdog; timeout is tied low and max_cycles is ignored
//
// Ports
//   CLK            clock, all logic on posedge
//   reset          synchronous active-low reset
//   start          run request, honoured only in IDLE or DONE
//   start_pc       program entry PC (latched on accepted start)
//   stop_pc        run ends once currentpc >= stop_pc, unsigned (latched)
//   max_cycles     RUN-cycle budget for the watchdog (latched)
//   cpu_reset      core reset, active high
//   cpu_startpc    core start PC
//   cpu_currentpc  core current PC
//   cpu_m2r        core MemtoRegOut
//   busy           high in RESET, SYNC and RUN
//   done           high in DONE, held until the next accepted start
//   result         last cpu_m2r captured in RUN
//   cycles         RUN cycles executed, saturating
//   sync_err       core never showed start_pc within SYNC_LIMIT cycles
//   timeout        watchdog expiry
module cpu_run_controller #(
  parameter int PC_W         = 64,
  parameter int CYC_W        = 16,
  parameter int RESET_CYCLES = 1,
  parameter int SYNC_LIMIT   = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  start_pc,
  input  logic [PC_W-1:0]  stop_pc,
  input  logic [CYC_W-1:0] max_cycles,
  output logic             cpu_reset,
  output logic [PC_W-1:0]  cpu_startpc,
  input  logic [PC_W-1:0]  cpu_currentpc,
  input  logic [PC_W-1:0]  cpu_m2r,
  output logic             busy,
  output logic             done,
  output logic [PC_W-1:0]  result,
  output logic [CYC_W-1:0] cycles,
  output logic             sync_err,
  output logic             timeout
);

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int SC_W = (SYNC_LIMIT > 1) ? $clog2(SYNC_LIMIT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_SYNC,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   start_q;
  logic [PC_W-1:0]   stop_q;
  logic [RC_W-1:0]   rst_cnt;
  logic [SC_W-1:0]   sync_cnt;
  logic              at_stop;
  logic              sync_hit;
  logic              wd_hit;

`ifdef WATCHDOG_EN
  logic [CYC_W-1:0]  max_q;

  // A zero budget means the watchdog is off for this run.
  assign wd_hit = (max_q != '0) && (cycles == max_q);
`else
  logic              unused_max;

  assign unused_max = ^max_cycles;
  assign wd_hit     = 1'b0;
  assign timeout    = 1'b0;
`endif

  assign at_stop  = (cpu_currentpc >= stop_q);
  assign sync_hit = (cpu_currentpc == start_q);

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cpu_reset   <= 1'b1;
      cpu_startpc <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sync_err    <= 1'b0;
      result      <= '0;
      cycles      <= '0;
      start_q     <= '0;
      stop_q      <= '0;
      rst_cnt     <= '0;
      sync_cnt    <= '0;
`ifdef WATCHDOG_EN
      timeout     <= 1'b0;
      max_q       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            start_q     <= start_pc;
            stop_q      <= stop_pc;
            cpu_startpc <= start_pc;
            cpu_reset   <= 1'b1;
            result      <= '0;
            cycles      <= '0;
            done        <= 1'b0;
            sync_err    <= 1'b0;
            busy        <= 1'b1;
            rst_cnt     <= '0;
            state       <= ST_RESET;
`ifdef WATCHDOG_EN
            max_q       <= max_cycles;
            timeout     <= 1'b0;
`endif
          end
        end

        ST_RESET: begin
          if (rst_cnt == RC_W'(RESET_CYCLES - 1)) begin
            cpu_reset <= 1'b0;
            sync_cnt  <= '0;
            state     <= ST_SYNC;
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end

        // The core advances one instruction per cycle once released, so the
        // cycle in which it first shows start_pc is already executing the
        // entry instruction; that cycle is treated as the first RUN cycle so
        // the entry instruction's MemtoRegOut is not lost.
        ST_SYNC, ST_RUN: begin
          if (state == ST_SYNC && !sync_hit) begin
            if (sync_cnt == SC_W'(SYNC_LIMIT - 1)) begin
              sync_err <= 1'b1;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= ST_DONE;
            end else begin
              sync_cnt <= sync_cnt + SC_W'(1);
            end
          end else if (at_stop) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (wd_hit) begin
`ifdef WATCHDOG_EN
            timeout <= 1'b1;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            result <= cpu_m2r;
            if (cycles != '1) begin
              cycles <= cycles + CYC_W'(1);
            end
            state <= ST_RUN;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
